// File: rtl/systolic_bs_array_pkg.sv
// Shared types and helpers for the bit-serial systolic array: controller states,
// weight-precision clamp and the saturating accumulator add.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    // Zero precision means one bit; anything above the array maximum is cut down to it.
    function automatic logic [3:0] clamp_prec(input logic [3:0] p, input int max_prec);
        if (p == 4'd0) return 4'd1;
        if (int'(p) > max_prec) return 4'(max_prec);
        return p;
    endfunction

    // Operands arrive sign-extended to 64 bits; result is clamped to a signed w-bit range (w <= 62).
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int w);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = a + b;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

endpackage

// File: rtl/systolic_bs_array_if.sv
// Job-control, input-beat and result-drain signals of the systolic array.
// valid/ready: a beat or result transfers on a rising clk edge where valid and ready are both high;
// the producer keeps data stable while valid is high and ready is low.
interface systolic_bs_array_if #(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int ACT_WIDTH = 16,
    parameter int ACC_WIDTH = 32,
    parameter int KLEN_W    = 12
);
    import systolic_pkg::*;

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    logic                        start;
    logic [KLEN_W-1:0]           k_len;
    logic [3:0]                  precision;
    logic [4:0]                  exp_set;
    logic                        in_valid;
    logic                        in_ready;
    logic [ROWS*ACT_WIDTH-1:0]   act_in;
    logic [COLS-1:0]             w_in;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [ACC_WIDTH-1:0] out_data;
    logic [RW-1:0]               out_row;
    logic [CW-1:0]               out_col;
    logic [4:0]                  out_exp;
    logic                        busy;
    logic                        done;
    state_t                      state;

    modport master (
        output start, k_len, precision, exp_set, in_valid, act_in, w_in, out_ready,
        input  in_ready, out_valid, out_data, out_row, out_col, out_exp, busy, done, state
    );

    modport slave (
        input  start, k_len, precision, exp_set, in_valid, act_in, w_in, out_ready,
        output in_ready, out_valid, out_data, out_row, out_col, out_exp, busy, done, state
    );

endinterface

// File: rtl/systolic_bs_array_bs_mac_pe.sv
// Bit-serial MAC cell: MSB-first weight bits against a held activation; forwards act/flags
// right and the weight bit down. Build with SYSTOLIC_ACC_SAT_EN for a saturating accumulator.
module bs_mac_pe
    import systolic_pkg::*;
#(
    parameter int ACT_WIDTH = 16,
    parameter int ACC_WIDTH = 32,
    parameter int MAX_PREC  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        clr,
    input  logic signed [ACT_WIDTH-1:0] act_in,
    input  logic                        first_in,
    input  logic                        last_in,
    input  logic                        w_in,
    output logic signed [ACT_WIDTH-1:0] act_out,
    output logic                        first_out,
    output logic                        last_out,
    output logic                        w_out,
    output logic signed [ACC_WIDTH-1:0] acc
);
    localparam int PW = ACT_WIDTH + MAX_PREC;

    logic signed [PW-1:0]        partial;
    logic signed [PW-1:0]        partial_nx;
    logic signed [PW-1:0]        act_ext;
    logic signed [ACC_WIDTH-1:0] acc_nx;

    // The MSB of a two's-complement weight carries negative weight.
    always_comb begin
        act_ext = PW'(act_in);
        if (first_in) partial_nx = w_in ? -act_ext : '0;
        else          partial_nx = (partial <<< 1) + (w_in ? act_ext : '0);
`ifdef SYSTOLIC_ACC_SAT_EN
        acc_nx = ACC_WIDTH'(sat_add(64'(acc), 64'(partial_nx), ACC_WIDTH));
`else
        acc_nx = acc + ACC_WIDTH'(partial_nx);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            act_out   <= '0;
            first_out <= 1'b0;
            last_out  <= 1'b0;
            w_out     <= 1'b0;
            partial   <= '0;
            acc       <= '0;
        end else if (en) begin
            act_out   <= act_in;
            first_out <= first_in;
            last_out  <= last_in;
            w_out     <= w_in;
            partial   <= partial_nx;
            if (last_in) acc <= acc_nx;
        end
    end

endmodule

// File: rtl/systolic_bs_array.sv
// R x C output-stationary bit-serial systolic array with run/drain/readout controller.
// Optional SYSTOLIC_ACC_SAT_EN selects saturating PE accumulation.
module systolic_bs_array
    import systolic_pkg::*;
#(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int ACT_WIDTH = 16,
    parameter int ACC_WIDTH = 32,
    parameter int MAX_PREC  = 8,
    parameter int KLEN_W    = 12
) (
    input logic clk,
    input logic rst,
    systolic_bs_array_if.slave bus
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int DW = (ROWS + COLS > 1) ? $clog2(ROWS + COLS) : 1;

    state_t            state, state_nx;
    logic [KLEN_W-1:0] k_r, elem_cnt;
    logic [3:0]        p_r, bit_cnt;
    logic [4:0]        exp_r;
    logic [DW-1:0]     drain_cnt;
    logic [RW-1:0]     row_idx;
    logic [CW-1:0]     col_idx;
    logic              done_r;
    logic              beat, en, clr, last_bit, last_elem, drain_end, out_hs, last_out;

    logic signed [ACT_WIDTH-1:0] act_hold [ROWS];
    logic signed [ACT_WIDTH-1:0] inj_act  [ROWS];
    logic                        inj_first, inj_last;
    logic [COLS-1:0]             inj_w;

    logic signed [ACT_WIDTH-1:0] act_h   [ROWS][COLS+1];
    logic                        first_h [ROWS][COLS+1];
    logic                        last_h  [ROWS][COLS+1];
    logic                        w_v     [ROWS+1][COLS];
    logic signed [ACC_WIDTH-1:0] acc_arr [ROWS][COLS];

    always_comb begin
        beat      = (state == RUN) && bus.in_valid;
        en        = beat || (state == DRAIN);
        clr       = (state == IDLE) && bus.start;
        last_bit  = (bit_cnt == p_r - 4'd1);
        last_elem = (elem_cnt == k_r - KLEN_W'(1));
        drain_end = (drain_cnt == DW'(ROWS + COLS - 1));
        out_hs    = (state == OUT) && bus.out_ready;
        last_out  = (row_idx == RW'(ROWS - 1)) && (col_idx == CW'(COLS - 1));
        state_nx  = state;
        case (state)
            IDLE:  if (bus.start) state_nx = (bus.k_len == '0) ? OUT : RUN;
            RUN:   if (beat && last_bit && last_elem) state_nx = DRAIN;
            DRAIN: if (drain_end) state_nx = OUT;
            OUT:   if (out_hs && last_out) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Activations are only valid on the MSB beat; later beats of the element replay the held copy.
    always_comb begin
        inj_first = (state == RUN) && (bit_cnt == 4'd0);
        inj_last  = (state == RUN) && last_bit;
        inj_w     = (state == RUN) ? bus.w_in : '0;
        for (int r = 0; r < ROWS; r++) begin
            inj_act[r] = '0;
            if (state == RUN)
                inj_act[r] = (bit_cnt == 4'd0) ? bus.act_in[r*ACT_WIDTH +: ACT_WIDTH] : act_hold[r];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            k_r       <= '0;
            elem_cnt  <= '0;
            p_r       <= '0;
            bit_cnt   <= '0;
            exp_r     <= '0;
            drain_cnt <= '0;
            row_idx   <= '0;
            col_idx   <= '0;
            done_r    <= 1'b0;
            for (int r = 0; r < ROWS; r++) act_hold[r] <= '0;
        end else begin
            state  <= state_nx;
            done_r <= out_hs && last_out;
            if (clr) begin
                k_r       <= bus.k_len;
                p_r       <= clamp_prec(bus.precision, MAX_PREC);
                exp_r     <= bus.exp_set;
                elem_cnt  <= '0;
                bit_cnt   <= '0;
                drain_cnt <= '0;
                row_idx   <= '0;
                col_idx   <= '0;
            end
            if (beat) begin
                if (bit_cnt == 4'd0)
                    for (int r = 0; r < ROWS; r++) act_hold[r] <= bus.act_in[r*ACT_WIDTH +: ACT_WIDTH];
                if (last_bit) begin
                    bit_cnt  <= '0;
                    elem_cnt <= elem_cnt + KLEN_W'(1);
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end
            if (state == DRAIN) drain_cnt <= drain_cnt + DW'(1);
            if (out_hs) begin
                if (col_idx == CW'(COLS - 1)) begin
                    col_idx <= '0;
                    row_idx <= (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + RW'(1);
                end else begin
                    col_idx <= col_idx + CW'(1);
                end
            end
        end
    end

    // Row r enters r en-cycles late and column c enters c en-cycles late, so operands meet at PE(r,c).
    for (genvar r = 0; r < ROWS; r++) begin : g_row_skew
        if (r == 0) begin : g_direct
            assign act_h[r][0]   = inj_act[r];
            assign first_h[r][0] = inj_first;
            assign last_h[r][0]  = inj_last;
        end else begin : g_delay
            logic signed [ACT_WIDTH-1:0] d_act [r];
            logic                        d_first [r];
            logic                        d_last  [r];
            always_ff @(posedge clk) begin
                if (!rst || clr) begin
                    for (int i = 0; i < r; i++) begin
                        d_act[i]   <= '0;
                        d_first[i] <= 1'b0;
                        d_last[i]  <= 1'b0;
                    end
                end else if (en) begin
                    d_act[0]   <= inj_act[r];
                    d_first[0] <= inj_first;
                    d_last[0]  <= inj_last;
                    for (int i = 1; i < r; i++) begin
                        d_act[i]   <= d_act[i-1];
                        d_first[i] <= d_first[i-1];
                        d_last[i]  <= d_last[i-1];
                    end
                end
            end
            assign act_h[r][0]   = d_act[r-1];
            assign first_h[r][0] = d_first[r-1];
            assign last_h[r][0]  = d_last[r-1];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col_skew
        if (c == 0) begin : g_direct
            assign w_v[0][c] = inj_w[c];
        end else begin : g_delay
            logic d_w [c];
            always_ff @(posedge clk) begin
                if (!rst || clr) begin
                    for (int i = 0; i < c; i++) d_w[i] <= 1'b0;
                end else if (en) begin
                    d_w[0] <= inj_w[c];
                    for (int i = 1; i < c; i++) d_w[i] <= d_w[i-1];
                end
            end
            assign w_v[0][c] = d_w[c-1];
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_r
        for (genvar c = 0; c < COLS; c++) begin : g_c
            bs_mac_pe #(
                .ACT_WIDTH(ACT_WIDTH),
                .ACC_WIDTH(ACC_WIDTH),
                .MAX_PREC (MAX_PREC)
            ) u_pe (
                .clk      (clk),
                .rst      (rst),
                .en       (en),
                .clr      (clr),
                .act_in   (act_h[r][c]),
                .first_in (first_h[r][c]),
                .last_in  (last_h[r][c]),
                .w_in     (w_v[r][c]),
                .act_out  (act_h[r][c+1]),
                .first_out(first_h[r][c+1]),
                .last_out (last_h[r][c+1]),
                .w_out    (w_v[r+1][c]),
                .acc      (acc_arr[r][c])
            );
        end
    end

    assign bus.in_ready  = (state == RUN);
    assign bus.out_valid = (state == OUT);
    assign bus.out_data  = acc_arr[row_idx][col_idx];
    assign bus.out_row   = row_idx;
    assign bus.out_col   = col_idx;
    assign bus.out_exp   = exp_r;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_r;
    assign bus.state     = state;

endmodule

// File: tb/tb_systolic_bs_array.sv
// Directed bench for a 2x2 systolic_bs_array: hand-computed dot products, stalls,
// readout back-pressure, precision clamp, K=0, overflow and mid-run reset.
module tb_systolic_bs_array;
    localparam int ROWS = 2, COLS = 2, ACT_WIDTH = 16, ACC_WIDTH = 32, MAX_PREC = 8, KLEN_W = 12;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    systolic_bs_array_if #(.ROWS(ROWS), .COLS(COLS), .ACT_WIDTH(ACT_WIDTH),
                           .ACC_WIDTH(ACC_WIDTH), .KLEN_W(KLEN_W)) bus ();

    systolic_bs_array #(.ROWS(ROWS), .COLS(COLS), .ACT_WIDTH(ACT_WIDTH), .ACC_WIDTH(ACC_WIDTH),
                        .MAX_PREC(MAX_PREC), .KLEN_W(KLEN_W)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

`ifdef SYSTOLIC_ACC_SAT_EN
    localparam int OVF_EXP = 32'h7fff_ffff;
`else
    localparam int OVF_EXP = 32'h8000_0000;
`endif

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_in_ready"}, bus.in_ready, 0);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_out_data"}, bus.out_data, 0);
        chk({tag, "_out_row"}, bus.out_row, 0);
        chk({tag, "_out_col"}, bus.out_col, 0);
        chk({tag, "_out_exp"}, bus.out_exp, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
    endtask

    task automatic start_job(input int k, input int p, input int e);
        bus.k_len     = KLEN_W'(k);
        bus.precision = 4'(p);
        bus.exp_set   = 5'(e);
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // One element: act lanes on the MSB beat only, then p weight bits MSB-first per column.
    task automatic feed_elem(input logic [31:0] acts, input logic [7:0] w0, input logic [7:0] w1,
                             input int p, input bit stall);
        for (int b = p - 1; b >= 0; b--) begin
            if (stall) begin
                int n;
                n = 0;
                while ($urandom_range(0, 1) == 1 && n < 6) begin
                    bus.in_valid = 1'b0;
                    tick();
                    n++;
                end
            end
            bus.in_valid = 1'b1;
            bus.act_in   = (b == p - 1) ? acts : 32'($urandom);
            bus.w_in     = {w1[b], w0[b]};
            tick();
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic wait_out(input string tag);
        int n;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_reach_out"}, bus.out_valid, 1);
    endtask

    task automatic read_all(input string tag, input int e0, input int e1, input int e2, input int e3,
                            input int ex, input bit hold, input bit start_on_last);
        int exp_d [4];
        exp_d = '{e0, e1, e2, e3};
        wait_out(tag);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (hold && i == 1) begin
                bus.out_ready = 1'b0;
                repeat (5) begin
                    tick();
                    chk({tag, "_hold_row"}, bus.out_row, 0);
                    chk({tag, "_hold_col"}, bus.out_col, 1);
                    chk({tag, "_hold_data"}, bus.out_data, exp_d[1]);
                end
                bus.out_ready = 1'b1;
            end
            chk({tag, "_valid"}, bus.out_valid, 1);
            chk({tag, "_row"}, bus.out_row, i / 2);
            chk({tag, "_col"}, bus.out_col, i % 2);
            chk({tag, "_data"}, bus.out_data, exp_d[i]);
            chk({tag, "_exp"}, bus.out_exp, ex);
            if (start_on_last && i == 3) begin
                bus.k_len = KLEN_W'(1);
                bus.start = 1'b1;
            end
            tick();
            bus.start = 1'b0;
        end
        chk({tag, "_done_pulse"}, bus.done, 1);
        chk({tag, "_busy_low"}, bus.busy, 0);
        chk({tag, "_valid_low"}, bus.out_valid, 0);
        tick();
        chk({tag, "_done_once"}, bus.done, 0);
        chk({tag, "_stay_idle"}, bus.busy, 0);
    endtask

    logic [31:0] act_a, act_b, act_ovf;

    initial begin
        act_a   = {16'hFFFE, 16'h0003};
        act_b   = {16'h0001, 16'h0001};
        act_ovf = {16'h8000, 16'h8000};
        bus.start     = 1'b0;
        bus.k_len     = '0;
        bus.precision = '0;
        bus.exp_set   = '0;
        bus.in_valid  = 1'b0;
        bus.act_in    = '0;
        bus.w_in      = '0;
        bus.out_ready = 1'b1;

        rst = 1'b0;
        repeat (3) tick();
        reset_checks("reset");
        rst = 1'b1;
        tick();

        // K=1, P=4: weights 5 and -3 against acts 3 and -2
        start_job(1, 4, 3);
        chk("t1_in_ready", bus.in_ready, 1);
        feed_elem(act_a, 8'h05, 8'h0D, 4, 1'b0);
        read_all("t1", 15, -9, -10, 6, 3, 1'b0, 1'b0);

        // K=2: second element adds act*2 per row
        start_job(2, 4, 7);
        feed_elem(act_a, 8'h05, 8'h0D, 4, 1'b0);
        feed_elem(act_b, 8'h02, 8'h02, 4, 1'b0);
        read_all("t2", 17, -7, -8, 8, 7, 1'b0, 1'b0);

        // random input stalls, plus a start pulse that must be ignored while busy
        start_job(1, 4, 11);
        bus.k_len = '0;
        bus.start = 1'b1;
        feed_elem(act_a, 8'h05, 8'h0D, 4, 1'b1);
        bus.start = 1'b0;
        read_all("t3", 15, -9, -10, 6, 11, 1'b0, 1'b0);

        // out_ready held low for 5 cycles before the second result
        start_job(1, 4, 13);
        feed_elem(act_a, 8'h05, 8'h0D, 4, 1'b0);
        read_all("t4", 15, -9, -10, 6, 13, 1'b1, 1'b0);

        // precision 0 behaves as a single negative-weight bit
        start_job(1, 0, 1);
        feed_elem(act_a, 8'h01, 8'h00, 1, 1'b0);
        read_all("t5", -3, 0, 2, 0, 1, 1'b0, 1'b0);

        // precision 9 clamps to 8 bits: 0000_0101 and 1111_1101
        start_job(1, 9, 2);
        feed_elem(act_a, 8'h05, 8'hFD, 8, 1'b0);
        read_all("t6", 15, -9, -10, 6, 2, 1'b0, 1'b0);

        // K=0: zero results, start on the final handshake is ignored
        start_job(0, 4, 21);
        read_all("t7", 0, 0, 0, 0, 21, 1'b0, 1'b1);

        // 512 x (-32768 * -128) = 2^31 overflows the accumulator
        start_job(512, 8, 30);
        repeat (512) feed_elem(act_ovf, 8'h80, 8'h80, 8, 1'b0);
        read_all("t8", OVF_EXP, OVF_EXP, OVF_EXP, OVF_EXP, 30, 1'b0, 1'b0);

        // reset in the middle of RUN
        start_job(3, 4, 9);
        feed_elem(act_a, 8'h05, 8'h0D, 4, 1'b0);
        chk("t9_mid_run", bus.in_ready, 1);
        rst = 1'b0;
        tick();
        reset_checks("t9");
        rst = 1'b1;
        tick();

        // a fresh job after reset still computes correctly
        start_job(1, 4, 4);
        feed_elem(act_a, 8'h05, 8'h0D, 4, 1'b0);
        read_all("t10", 15, -9, -10, 6, 4, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
